// File: rtl/alu_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Bus bundle between the control unit / register file (master)
//               and the sequential ALU (slave).
//               master drives : Start, ALUCtrl, BusA, BusB
//               slave drives  : BusW, Zero, Negative, Carry, Overflow,
//                               Busy, Done
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             Start;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic [WIDTH-1:0] BusW;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, ALUCtrl, BusA, BusB,
        input  BusW, Zero, Negative, Carry, Overflow, Busy, Done
    );

    modport slave (
        input  Start, ALUCtrl, BusA, BusB,
        output BusW, Zero, Negative, Carry, Overflow, Busy, Done
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with NZCV flags. Single-cycle logic, add/sub
//               and shift operations; iterative shift-add multiply with
//               early exit once the remaining multiplier bits are zero.
// Ports       : CLK      - clock, rising edge
//               Reset    - asynchronous active-high reset
//               bus      - alu_seq_if.slave (Start/ALUCtrl/BusA/BusB in,
//                          BusW/Zero/Negative/Carry/Overflow/Busy/Done out)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  wire logic   CLK,
    input  wire logic   Reset,
    alu_seq_if.slave    bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_LSL  = 4'b0011;
    localparam logic [3:0] c_OP_LSR  = 4'b0100;
    localparam logic [3:0] c_OP_ASR  = 4'b0101;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_PASS = 4'b0111;
    localparam logic [3:0] c_OP_MUL  = 4'b1000;

    localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH - 1);

    generate
        if ((WIDTH < 8) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
            $error("alu_seq: WIDTH must be a power of two and at least 8");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // multiply datapath
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;

    // output registers
    logic [WIDTH-1:0] r_busw;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;
    logic             r_ovf;
    logic             r_done;

    // combinational
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic [WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0] w_mplier_sh;
    logic             w_mul_last;
    logic             w_mul_load;
    logic             w_mul_step;
    logic             w_res_load;
    logic [WIDTH-1:0] w_res;
    logic             w_res_c;
    logic             w_res_v;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    assign w_sh  = bus.BusB[SHW-1:0];
    assign w_sum = {1'b0, bus.BusA} + {1'b0, bus.BusB};
    // subtraction as A + ~B + 1 so the carry out means "no borrow"
    assign w_dif = {1'b0, bus.BusA} + {1'b0, ~bus.BusB} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (bus.ALUCtrl)
            c_OP_AND:  w_alu_res = bus.BusA & bus.BusB;
            c_OP_OR:   w_alu_res = bus.BusA | bus.BusB;
            c_OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (bus.BusA[WIDTH-1] == bus.BusB[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != bus.BusA[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_alu_res = w_dif[WIDTH-1:0];
                w_alu_c   = w_dif[WIDTH];
                w_alu_v   = (bus.BusA[WIDTH-1] != bus.BusB[WIDTH-1]) &&
                            (w_dif[WIDTH-1] != bus.BusA[WIDTH-1]);
            end
            c_OP_PASS: w_alu_res = bus.BusB;
            c_OP_LSL:  w_alu_res = bus.BusA << w_sh;
            c_OP_LSR:  w_alu_res = bus.BusA >> w_sh;
            c_OP_ASR:  w_alu_res = $unsigned($signed(bus.BusA) >>> w_sh);
            default:   w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply iteration
    // ------------------------------------------------------------------
    assign w_acc_step  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_sh = r_mplier >> 1;
    // Finish when no multiplier bits remain; the count test is a backstop
    // that coincides with the shifted multiplier being zero anyway.
    assign w_mul_last  = (r_cnt == c_CNT_LAST) || (w_mplier_sh == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mul_load  = 1'b0;
        w_mul_step  = 1'b0;
        w_res_load  = 1'b0;
        w_res       = '0;
        w_res_c     = 1'b0;
        w_res_v     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Start) begin
                    if (bus.ALUCtrl == c_OP_MUL) begin
                        w_mul_load  = 1'b1;
                        w_state_nxt = S_MUL;
                    end else begin
                        w_res_load = 1'b1;
                        w_res      = w_alu_res;
                        w_res_c    = w_alu_c;
                        w_res_v    = w_alu_v;
                    end
                end
            end
            S_MUL: begin
                w_mul_step = 1'b1;
                if (w_mul_last) begin
                    w_res_load  = 1'b1;
                    w_res       = w_acc_step;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_mul_load) begin
            r_mcand  <= bus.BusA;
            r_mplier <= bus.BusB;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_mul_step) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_sh;
            r_acc    <= w_acc_step;
            r_cnt    <= r_cnt + SHW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result and flag registers; values hold between operations
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_busw  <= '0;
            r_zero  <= 1'b1;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_res_load;
            if (w_res_load) begin
                r_busw  <= w_res;
                r_zero  <= (w_res == '0);
                r_neg   <= w_res[WIDTH-1];
                r_carry <= w_res_c;
                r_ovf   <= w_res_v;
            end
        end
    end

    assign bus.BusW     = r_busw;
    assign bus.Zero     = r_zero;
    assign bus.Negative = r_neg;
    assign bus.Carry    = r_carry;
    assign bus.Overflow = r_ovf;
    assign bus.Done     = r_done;
    assign bus.Busy     = (r_state == S_MUL);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed-vector bench for alu_seq with a scoreboard queue;
//               a monitor pops expectations whenever Done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam int WIDTH = 64;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LSL  = 4'b0011;
    localparam logic [3:0] OP_LSR  = 4'b0100;
    localparam logic [3:0] OP_ASR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] w;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        int          cyc;
    } exp_t;

    logic  CLK   = 1'b0;
    logic  Reset = 1'b1;
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;
    exp_t  sb[$];
    string nq[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Caller sits at a negedge; returns one negedge later with Start low.
    task automatic issue(input string nm, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] w,
                         input logic c, input logic v, input int k);
        exp_t e;
        bus.Start   = 1'b1;
        bus.ALUCtrl = op;
        bus.BusA    = a;
        bus.BusB    = b;
        e.w   = w;
        e.z   = (w == 64'd0);
        e.n   = w[63];
        e.c   = c;
        e.v   = v;
        e.cyc = cyc + 1 + ((op == OP_MUL) ? k : 0);
        sb.push_back(e);
        nq.push_back(nm);
        @(negedge CLK);
        bus.Start   = 1'b0;
        bus.ALUCtrl = 4'b1010;
        bus.BusA    = {$urandom, $urandom};
        bus.BusB    = {$urandom, $urandom};
        if (op == OP_MUL)
            chk({nm, "_busy"}, {127'd0, bus.Busy}, 128'd1);
    endtask

    // Monitor: pop and compare on every Done
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge CLK);
            if (bus.Done === 1'b1) begin
                chk("done_busy_excl", {127'd0, bus.Busy}, 128'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 128'd1, 128'd0);
                end else begin
                    e  = sb.pop_front();
                    nm = nq.pop_front();
                    chk({nm, "_res"},
                        {60'd0, bus.BusW, bus.Zero, bus.Negative, bus.Carry, bus.Overflow},
                        {60'd0, e.w, e.z, e.n, e.c, e.v});
                    chk({nm, "_cyc"}, 128'(cyc), 128'(e.cyc));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bus.Start   = 1'b0;
        bus.ALUCtrl = 4'd0;
        bus.BusA    = '0;
        bus.BusB    = '0;
        repeat (2) @(negedge CLK);
        chk("reset_state",
            {59'd0, bus.BusW, bus.Zero, bus.Negative, bus.Carry, bus.Overflow, bus.Busy, bus.Done},
            {59'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        Reset = 1'b0;
        @(negedge CLK);

        // back-to-back single-cycle operations
        issue("add_ovf",   OP_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, MSB, 1'b0, 1'b1, 0);
        issue("add_carry", OP_ADD,  ONES, 64'd1, 64'd0, 1'b1, 1'b0, 0);
        issue("sub_5_7",   OP_SUB,  64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
        issue("sub_7_5",   OP_SUB,  64'd7, 64'd5, 64'd2, 1'b1, 1'b0, 0);
        issue("and",       OP_AND,  64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0, 0);
        issue("or",        OP_OR,   64'hF0F0, 64'h0FF0, 64'hFFF0, 1'b0, 1'b0, 0);
        issue("passb",     OP_PASS, 64'hF0F0, 64'h0FF0, 64'h0FF0, 1'b0, 1'b0, 0);
        issue("passb_0",   OP_PASS, 64'hF0F0, 64'd0, 64'd0, 1'b0, 1'b0, 0);
        issue("lsl_63",    OP_LSL,  64'd1, 64'd63, MSB, 1'b0, 1'b0, 0);
        issue("lsr_63",    OP_LSR,  MSB, 64'd63, 64'd1, 1'b0, 1'b0, 0);
        issue("asr_neg",   OP_ASR,  MSB, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1'b0, 0);
        issue("lsl_sh0",   OP_LSL,  64'h1234, 64'h40, 64'h1234, 1'b0, 1'b0, 0);
        issue("asr_pos",   OP_ASR,  64'h4000_0000_0000_0000, 64'd4,
              64'h0400_0000_0000_0000, 1'b0, 1'b0, 0);
        issue("sub_ovf",   OP_SUB,  MSB, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);
        issue("bad_op",    4'b1111, 64'hFF, 64'd1, 64'd0, 1'b0, 1'b0, 0);
        @(negedge CLK);

        // multiplies: wait k+1 negedges after issue returns
        issue("mul_32x32", OP_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF,
              64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 32);
        repeat (33) @(negedge CLK);
        issue("mul_m3x5", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
              64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0, 3);
        repeat (4) @(negedge CLK);
        issue("mul_x0", OP_MUL, 64'h1234, 64'd0, 64'd0, 1'b0, 1'b0, 1);
        repeat (2) @(negedge CLK);
        issue("mul_bmsb", OP_MUL, 64'd3, MSB, MSB, 1'b0, 1'b0, 64);
        repeat (65) @(negedge CLK);
        issue("mul_5xm3", OP_MUL, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD,
              64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0, 64);
        repeat (65) @(negedge CLK);

        // Start while busy is ignored; Start during the Done cycle is accepted
        issue("mul_7x6", OP_MUL, 64'd7, 64'd6, 64'd42, 1'b0, 1'b0, 3);
        bus.Start   = 1'b1;
        bus.ALUCtrl = OP_ADD;
        bus.BusA    = 64'd1;
        bus.BusB    = 64'd1;
        @(negedge CLK);
        bus.Start = 1'b0;
        repeat (2) @(negedge CLK);
        issue("sub_on_done", OP_SUB, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0, 0);
        repeat (2) @(negedge CLK);

        // asynchronous reset in the middle of a multiply
        issue("mul_aborted", OP_MUL, 64'd3, MSB, MSB, 1'b0, 1'b0, 64);
        repeat (10) @(negedge CLK);
        #2 Reset = 1'b1;
        #1;
        chk("reset_mid_mul",
            {59'd0, bus.BusW, bus.Zero, bus.Negative, bus.Carry, bus.Overflow, bus.Busy, bus.Done},
            {59'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        sb.delete();
        nq.delete();
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        issue("or_after_rst", OP_OR, 64'hF0F0, 64'h0FF0, 64'hFFF0, 1'b0, 1'b0, 0);
        repeat (4) @(negedge CLK);

        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
